// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared types and constants for the MAC transmit path.
//   tx_fcs_state_t : sequencer states of mac_tx_fcs_ctrl
//   CRC32_POLY     : IEEE 802.3 CRC-32 generator polynomial (normal form)
//   CRC32_INIT     : CRC seed loaded at the start of each frame
//   FCS_BYTES      : number of FCS bytes appended to a frame
//   sat_inc16      : 16-bit increment that sticks at all-ones
// ---------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_PAD  = 3'd2,
    ST_FCS  = 3'd3,
    ST_IFG  = 3'd4
  } tx_fcs_state_t;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam int          FCS_BYTES  = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mac_lfsr.sv
// ---------------------------------------------------------------------------
// mac_lfsr
// Purely combinational LFSR next-state function. Advances the register
// supplied on lfsr_initial_state_in by DATA_WIDTH bit steps while shifting in
// data_in, and returns the result on lfsr_state_out. The caller owns the
// state register.
//   LFSR_WIDTH / LFSR_POLY : register width and polynomial (normal form)
//   LFSR_CONFIG            : "GALOIS" or "FIBONACCI"
//   LFSR_FEED_FORWARD      : 1 keeps data out of the feedback path
//   REVERSE                : 1 = LSB-first data and bit-reflected register
//   DATA_WIDTH             : bits consumed per evaluation
// Ports:
//   data_in               in  DATA_WIDTH  input data word
//   lfsr_initial_state_in in  LFSR_WIDTH  current register value
//   lfsr_state_out        out LFSR_WIDTH  register value after DATA_WIDTH steps
// ---------------------------------------------------------------------------
module mac_lfsr #(
  parameter int                    LFSR_WIDTH        = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 32'h04C11DB7,
  parameter string                 LFSR_CONFIG       = "GALOIS",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b1,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] lfsr_initial_state_in,
  output logic [LFSR_WIDTH-1:0] lfsr_state_out
);

  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");

  function automatic logic [LFSR_WIDTH-1:0] rev_w(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int k = 0; k < LFSR_WIDTH; k++) begin
      r[k] = v[LFSR_WIDTH-1-k];
    end
    return r;
  endfunction

  // The reflected form is evaluated as the normal (MSB-first, shift-left)
  // form on a bit-reversed register, so only one step equation is needed.
  logic [LFSR_WIDTH-1:0] work;
  logic                  tap;
  logic                  din;
  logic                  fb;

  always_comb begin
    work = REVERSE ? rev_w(lfsr_initial_state_in) : lfsr_initial_state_in;
    tap  = 1'b0;
    din  = 1'b0;
    fb   = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      din = REVERSE ? data_in[i] : data_in[DATA_WIDTH-1-i];
      if (IS_GALOIS) begin
        tap  = work[LFSR_WIDTH-1];
        fb   = LFSR_FEED_FORWARD ? tap : (tap ^ din);
        work = {work[LFSR_WIDTH-2:0], 1'b0};
        if (fb) begin
          work = work ^ LFSR_POLY;
        end
      end else begin
        tap  = work[LFSR_WIDTH-1] ^ (^(work[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]));
        fb   = LFSR_FEED_FORWARD ? tap : (tap ^ din);
        work = {work[LFSR_WIDTH-2:0], fb};
      end
    end
    lfsr_state_out = REVERSE ? rev_w(work) : work;
  end

endmodule

// File: rtl/mac_tx_fcs_ctrl.sv
// ---------------------------------------------------------------------------
// mac_tx_fcs_ctrl
// Transmit frame sequencer: passes frame bytes through a one-deep output
// register, zero-pads short frames up to MIN_FRAME_BYTES, appends the
// 4-byte CRC-32 FCS (LSB byte first) and holds off the source for
// IFG_CYCLES after each frame.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tlast/s_tready   byte stream from the frame buffer
//   m_tdata/m_tvalid/m_tlast/m_tready   byte stream to the PHY side
//   busy               state is not IDLE
//   frame_done         pulse on the handshake of the last FCS byte
//   fcs_out            FCS of the last completed frame
//   dbg_state          current sequencer state
//
// Handshake: a byte moves on any cycle where valid && ready at the rising
// edge. Once m_tvalid is raised, m_tdata/m_tlast stay put until m_tready;
// s_tready never depends on s_tvalid.
// ---------------------------------------------------------------------------
module mac_tx_fcs_ctrl
  import mac_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 60,
  parameter bit ENABLE_PAD      = 1'b1,
  parameter int IFG_CYCLES      = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [7:0]    m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic          busy,
  output logic          frame_done,
  output logic [31:0]   fcs_out,
  output tx_fcs_state_t dbg_state
);

  localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
  localparam logic [2:0]  FCS_END  = 3'(FCS_BYTES);

  tx_fcs_state_t state_q;
  logic [31:0]   crc_q;
  logic [31:0]   fcs_out_q;
  logic [15:0]   cnt_q;
  logic [15:0]   ifg_cnt_q;
  logic [2:0]    fcs_idx_q;   // FCS bytes already loaded into the output register
  logic [7:0]    m_tdata_q;
  logic          m_tvalid_q;
  logic          m_tlast_q;
  logic          rdy_en_q;    // keeps s_tready low for the first cycle out of reset

  logic          out_adv;
  logic          in_hs;
  logic          out_hs;
  logic [31:0]   lfsr_seed;
  logic [7:0]    lfsr_byte;
  logic [31:0]   crc_next;
  logic [15:0]   cnt_inc;
  logic          need_pad;
  logic [31:0]   fcs_word;
  logic [7:0]    fcs_byte;

  // Output register can take a new byte this cycle.
  assign out_adv  = !m_tvalid_q || m_tready;
  assign s_tready = rdy_en_q && ((state_q == ST_IDLE) || (state_q == ST_DATA)) && out_adv;
  assign in_hs    = s_tvalid && s_tready;
  assign out_hs   = m_tvalid_q && m_tready;

  // The first byte of a frame is folded into the init value directly, so the
  // seed and the first update happen in one cycle.
  assign lfsr_seed = (state_q == ST_IDLE) ? CRC32_INIT : crc_q;
  assign lfsr_byte = (state_q == ST_PAD) ? 8'h00 : s_tdata;
  assign cnt_inc   = (state_q == ST_IDLE) ? 16'd1 : sat_inc16(cnt_q);
  assign need_pad  = ENABLE_PAD && (cnt_inc < MIN_CNT);

  mac_lfsr #(
    .LFSR_WIDTH        (32),
    .LFSR_POLY         (CRC32_POLY),
    .LFSR_CONFIG       ("GALOIS"),
    .LFSR_FEED_FORWARD (1'b0),
    .REVERSE           (1'b1),
    .DATA_WIDTH        (8)
  ) u_crc (
    .data_in               (lfsr_byte),
    .lfsr_initial_state_in (lfsr_seed),
    .lfsr_state_out        (crc_next)
  );

  assign fcs_word = ~crc_q;

  always_comb begin
    fcs_byte = 8'h00;
    case (fcs_idx_q[1:0])
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      crc_q      <= CRC32_INIT;
      fcs_out_q  <= 32'h0;
      cnt_q      <= 16'h0;
      ifg_cnt_q  <= 16'h0;
      fcs_idx_q  <= 3'd0;
      m_tdata_q  <= 8'h00;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;

      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (in_hs) begin
            m_tdata_q  <= s_tdata;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= 1'b0;
            crc_q      <= crc_next;
            cnt_q      <= cnt_inc;
            if (s_tlast) begin
              state_q   <= need_pad ? ST_PAD : ST_FCS;
              fcs_idx_q <= 3'd0;
            end else begin
              state_q <= ST_DATA;
            end
          end else if (out_adv) begin
            m_tvalid_q <= 1'b0;
          end
        end

        ST_PAD: begin
          if (out_adv) begin
            m_tdata_q  <= 8'h00;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= 1'b0;
            crc_q      <= crc_next;
            cnt_q      <= cnt_inc;
            if (cnt_inc >= MIN_CNT) begin
              state_q   <= ST_FCS;
              fcs_idx_q <= 3'd0;
            end
          end
        end

        ST_FCS: begin
          // CRC is frozen here; the four FCS bytes are slices of ~crc_q.
          if (out_adv) begin
            if (fcs_idx_q != FCS_END) begin
              m_tdata_q  <= fcs_byte;
              m_tvalid_q <= 1'b1;
              m_tlast_q  <= (fcs_idx_q == FCS_END - 3'd1);
              fcs_idx_q  <= fcs_idx_q + 3'd1;
            end else begin
              // All FCS bytes loaded and out_adv with a valid byte means the
              // last byte is being accepted right now.
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              fcs_out_q  <= fcs_word;
              ifg_cnt_q  <= 16'h0;
              state_q    <= ST_IFG;
            end
          end
        end

        ST_IFG: begin
          ifg_cnt_q <= ifg_cnt_q + 16'd1;
          if (ifg_cnt_q >= IFG_LAST) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = out_hs && m_tlast_q;
  assign fcs_out    = fcs_out_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/mac_tx_fcs_ctrl.md
# mac_tx_fcs_ctrl

Transmit-side frame sequencer for the MAC: accepts a byte stream per frame, zero-pads short frames to the Ethernet minimum, drives the `mac_lfsr` CRC-32 engine byte by byte, appends the 4-byte FCS, and enforces the inter-frame gap. It sits between the TX frame buffer and the PHY-side byte interface. It owns the CRC state register; `mac_lfsr` is used as the combinational next-state function.

## Interface
- `MIN_FRAME_BYTES`, 60, minimum payload+header bytes before the FCS; shorter frames are padded with 0x00.
- `ENABLE_PAD`, 1, 0 disables padding; frames are sent as given.
- `IFG_CYCLES`, 12, idle cycles enforced after the last FCS byte handshake.
- `clk` in 1 — single clock.
- `rstn` in 1 — asynchronous, active-low reset.
- `s_tdata` in 8 — input frame byte.
- `s_tvalid` in 1 — input byte valid.
- `s_tlast` in 1 — marks the last input byte of the frame.
- `s_tready` out 1 — input byte accepted when `s_tvalid && s_tready`.
- `m_tdata` out 8 — output byte (data, pad or FCS).
- `m_tvalid` out 1 — output byte valid.
- `m_tlast` out 1 — set on the 4th FCS byte only.
- `m_tready` in 1 — downstream accept.
- `busy` out 1 — high in any state other than IDLE.
- `frame_done` out 1 — one-cycle pulse on the handshake of the `m_tlast` byte.
- `fcs_out` out 32 — FCS of the last completed frame; held until the next frame completes.

## Operation
- States: IDLE, DATA, PAD, FCS, IFG.
- IDLE: `s_tready` follows output-register availability. The first accepted byte seeds the CRC state with 32'hFFFFFFFF, clears the byte counter and moves to DATA. If that byte has `s_tlast` set, the next state is decided as in the DATA→ exit rule.
- DATA: each accepted byte is loaded into the output register and folded into the CRC: crc <= lfsr_state_out(crc, byte). The byte counter increments and saturates at 16'hFFFF.
- DATA exit on an accepted `s_tlast` byte with counter value n (after increment):
  - `ENABLE_PAD` and n < `MIN_FRAME_BYTES` → PAD.
  - otherwise → FCS.
- PAD: emits 0x00 bytes. Each one loaded into the output register updates the CRC and the counter. Moves to FCS when the counter reaches `MIN_FRAME_BYTES`. `s_tready` is 0.
- FCS: emits ~crc as 4 bytes, bits [7:0] first, then [15:8], [23:16], [31:24]. The CRC is frozen during FCS. `m_tlast` is set with byte 4. `fcs_out` <= ~crc on the byte-4 handshake; `frame_done` pulses on the same handshake. Next state is IFG.
- IFG: counts `IFG_CYCLES` cycles starting the cycle after the byte-4 handshake, then goes to IDLE. `s_tready` is 0.
- CRC engine configuration: `mac_lfsr` with LFSR_WIDTH 32, POLY 32'h04C11DB7, GALOIS, FEED_FORWARD 0, REVERSE 1, DATA_WIDTH 8.

## Timing
- Reset (async assert, sync deassert handled upstream): state IDLE, `s_tready` 0 for the first cycle after deassert, `m_tvalid` 0, `m_tdata` 0, `m_tlast` 0, `busy` 0, `frame_done` 0, `fcs_out` 0, crc 32'hFFFFFFFF.
- Output stage is one register deep. Latency from input handshake to `m_tvalid` is 1 cycle.
- `s_tready` = (state ∈ {IDLE, DATA}) && (!m_tvalid || m_tready).
- Backpressure: while `m_tvalid && !m_tready`, `m_tdata`/`m_tlast` hold and no CRC or counter update occurs.
- Throughput is 1 byte/cycle with `m_tready` held high, including across the DATA→PAD→FCS transitions (no bubbles). The only gap between frames is IFG.
- A frame with exactly `MIN_FRAME_BYTES` bytes gets no pad.
- `s_tvalid` during PAD/FCS/IFG is ignored; the input is held by the source.
- Reset mid-frame: immediate return to the reset values; the partial frame is dropped with no `m_tlast` and no `frame_done`.

## Structure
- `mac_pkg`: state enum `tx_fcs_state_t`, CRC32 polynomial constant, CRC init value 32'hFFFFFFFF, FCS byte count 4.
- One sub-module: `mac_lfsr`, instantiated with the CRC configuration above. Its `lfsr_initial_state_in` is driven from the controller's crc register, and `lfsr_state_out` is the next-state value.

## Test plan
- `ENABLE_PAD`=0, send ASCII "123456789" (0x31..0x39) with `m_tready`=1 → 13 output bytes; FCS bytes are 0x26, 0x39, 0xF4, 0xCB with `m_tlast` on 0xCB; `fcs_out`=32'hCBF43926.
- 1-byte frame 0xAA with pad on → 60 data bytes (0xAA, then 59×0x00) plus 4 FCS bytes, 64 total. The FCS matches a software CRC-32 of the 60 bytes.
- 60-byte frame → no pad, 64 output bytes. 61-byte frame → 65 output bytes.
- Random `m_tready` toggling (50%) on a 100-byte frame → output byte sequence identical to the `m_tready`=1 run; `m_tdata` never changes while stalled.
- Two back-to-back frames with `s_tvalid` held high → `s_tready` stays 0 for exactly 12 cycles after the `m_tlast` handshake; the second frame's FCS is correct (CRC reseeded).
- Assert `rstn`=0 mid-DATA after 20 bytes → all outputs at reset values, no `frame_done`; the next frame after reset produces the correct FCS.
